// File: rtl/bcd_count_ctrl.sv
// Two-digit BCD up-counter with an IDLE/RUN/PAUSE/DONE control FSM,
// a terminal-count compare, a preset load and a rejected-load error pulse.
module bcd_count_ctrl #(
  parameter int WRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] tc_val,
  input  logic       tick,
  output logic [3:0] q_ones,
  output logic [3:0] q_tens,
  output logic       carry,
  output logic       running,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic HOLD_AT_MAX = (WRAP == 0);

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic       err_q, err_d;
  logic [3:0] inc_ones, inc_tens;
  logic       load_ok, tc_ok, inc_en, at_max, hold_max;

  assign load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  assign tc_ok    = (tc_val[7:4] <= 4'd9) && (tc_val[3:0] <= 4'd9);
  assign inc_en   = (state_q == RUN) && tick && !clear && !load && !stop;
  assign at_max   = (ones_q == 4'd9) && (tens_q == 4'd9);
  assign hold_max = at_max && HOLD_AT_MAX;

  always_comb begin
    inc_ones = ones_q + 4'd1;
    inc_tens = tens_q;
    if (ones_q == 4'd9) begin
      inc_ones = 4'd0;
      inc_tens = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  // Command priority: clear > load > stop > start; the increment only
  // happens when none of clear/load/stop is present.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        ones_d = load_val[3:0];
        tens_d = load_val[7:4];
        if (state_q != RUN) state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
    end
    if (inc_en) begin
      if (hold_max) begin
        state_d = DONE;
      end else begin
        ones_d = inc_ones;
        tens_d = inc_tens;
        if (tc_ok && {inc_tens, inc_ones} == tc_val) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      err_q   <= err_d;
    end
  end

  assign q_ones    = ones_q;
  assign q_tens    = tens_q;
  assign carry     = inc_en && (ones_q == 4'd9) && !hold_max;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: WRAP=1 and WRAP=0 instances share stimulus and
// are checked every cycle against an integer-count model, plus literal pins.
module tb_bcd_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, tick = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] tc_val = 8'hFF;

  logic [3:0] q_ones [2];
  logic [3:0] q_tens [2];
  logic       carry [2], running [2], done [2], err [2];
  logic [1:0] state_dbg [2];

  int checks = 0;
  int errors = 0;
  int carry_cnt [2] = '{0, 0};

  // model: count as an integer 0..99, mode 0=idle 1=run 2=pause 3=done
  int m_cnt [2] = '{0, 0};
  int m_mode [2] = '{0, 0};
  int m_err [2] = '{0, 0};

  always #5 clk = ~clk;

  bcd_count_ctrl #(.WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .tc_val(tc_val), .tick(tick),
    .q_ones(q_ones[0]), .q_tens(q_tens[0]), .carry(carry[0]), .running(running[0]),
    .done(done[0]), .err(err[0]), .state_dbg(state_dbg[0]));

  bcd_count_ctrl #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .tc_val(tc_val), .tick(tick),
    .q_ones(q_ones[1]), .q_tens(q_tens[1]), .carry(carry[1]), .running(running[1]),
    .done(done[1]), .err(err[1]), .state_dbg(state_dbg[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit m_inc(input int w);
    return (m_mode[w] == 1) && tick && !clear && !load && !stop;
  endfunction

  function automatic bit m_carry(input int w);
    return m_inc(w) && (m_cnt[w] % 10 == 9) && !(w == 0 && m_cnt[w] == 99);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        m_cnt[w] = 0; m_mode[w] = 0; m_err[w] = 0;
      end else begin
        bit inc;
        inc = m_inc(w);
        m_err[w] = 0;
        if (clear) begin
          m_cnt[w] = 0; m_mode[w] = 0;
        end else if (load) begin
          if (bcd_ok(load_val)) begin
            m_cnt[w] = bcd2int(load_val);
            if (m_mode[w] != 1) m_mode[w] = 0;
          end else m_err[w] = 1;
        end else if (stop) begin
          if (m_mode[w] == 1) m_mode[w] = 2;
        end else if (start) begin
          if (m_mode[w] == 0 || m_mode[w] == 2) m_mode[w] = 1;
        end
        if (inc) begin
          if (w == 0 && m_cnt[w] == 99) m_mode[w] = 3;
          else begin
            m_cnt[w] = (m_cnt[w] + 1) % 100;
            if (bcd_ok(tc_val) && m_cnt[w] == bcd2int(tc_val)) m_mode[w] = 3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("w%0d q_tens", w), int'(q_tens[w]), m_cnt[w] / 10);
      chk($sformatf("w%0d q_ones", w), int'(q_ones[w]), m_cnt[w] % 10);
      chk($sformatf("w%0d running", w), int'(running[w]), int'(m_mode[w] == 1));
      chk($sformatf("w%0d done", w), int'(done[w]), int'(m_mode[w] == 3));
      chk($sformatf("w%0d err", w), int'(err[w]), m_err[w]);
      chk($sformatf("w%0d carry", w), int'(carry[w]), int'(m_carry(w)));
      if (carry[w]) carry_cnt[w]++;
    end
  end

  task automatic step(input logic s, input logic sp, input logic c, input logic l,
                      input logic t, input logic [7:0] lv);
    start = s; stop = sp; clear = c; load = l; tick = t; load_val = lv;
    @(posedge clk); #1;
    start = 0; stop = 0; clear = 0; load = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic pin(input string name, input int w, input logic [7:0] q,
                     input bit run, input bit dn);
    chk({name, " q"}, int'({q_tens[w], q_ones[w]}), int'(q));
    chk({name, " running"}, int'(running[w]), int'(run));
    chk({name, " done"}, int'(done[w]), int'(dn));
  endtask

  int c0, c1;

  initial begin
    rst = 1;
    #12;
    pin("reset w0", 0, 8'h00, 0, 0);
    pin("reset w1", 1, 8'h00, 0, 0);
    @(posedge clk); #1;
    rst = 0;

    // 12 ticks from zero: carry exactly once on the 9->10 tick
    tc_val = 8'hFF;
    step(1, 0, 0, 0, 0, 8'h00);
    c1 = carry_cnt[1];
    ticks(12);
    pin("count12", 1, 8'h12, 1, 0);
    chk("count12 carries", carry_cnt[1] - c1, 1);

    // terminal count at 99, ticks afterwards hold
    step(0, 0, 1, 0, 0, 8'h00);
    tc_val = 8'h99;
    step(0, 0, 0, 1, 0, 8'h97);
    step(1, 0, 0, 0, 0, 8'h00);
    ticks(2);
    pin("tc99 w1", 1, 8'h99, 0, 1);
    ticks(3);
    pin("tc99 hold w0", 0, 8'h99, 0, 1);
    step(0, 0, 0, 1, 0, 8'h10);
    pin("done exit by load", 1, 8'h10, 0, 0);
    tc_val = 8'h10;
    step(1, 0, 0, 0, 0, 8'h00);
    pin("start at tc", 1, 8'h10, 1, 0);

    // wrap vs hold from 98
    step(0, 0, 1, 0, 0, 8'h00);
    tc_val = 8'h50;
    step(0, 0, 0, 1, 0, 8'h98);
    step(1, 0, 0, 0, 0, 8'h00);
    c0 = carry_cnt[0]; c1 = carry_cnt[1];
    ticks(3);
    pin("wrap w1", 1, 8'h01, 1, 0);
    pin("hold w0", 0, 8'h99, 0, 1);
    chk("wrap carries w1", carry_cnt[1] - c1, 1);
    chk("hold carries w0", carry_cnt[0] - c0, 0);

    // rejected load, then clear wins over stop/start
    step(0, 0, 0, 1, 0, 8'h3A);
    chk("err pulse", int'(err[1]), 1);
    pin("bad load", 1, 8'h01, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00);
    chk("err ends", int'(err[1]), 0);
    step(1, 1, 1, 0, 1, 8'h00);
    pin("clear prio", 1, 8'h00, 0, 0);

    // stop with tick pauses without incrementing, start resumes
    tc_val = 8'hFF;
    step(1, 0, 0, 0, 0, 8'h00);
    ticks(3);
    step(0, 1, 0, 0, 1, 8'h00);
    pin("pause", 1, 8'h03, 0, 0);
    ticks(2);
    step(1, 0, 0, 0, 0, 8'h00);
    ticks(2);
    pin("resume", 1, 8'h05, 1, 0);
    step(0, 0, 0, 1, 1, 8'h20);
    ticks(1);
    pin("load in run", 1, 8'h21, 1, 0);

    // asynchronous reset mid-count
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h45);
    step(1, 0, 0, 0, 0, 8'h00);
    pin("at 45", 1, 8'h45, 1, 0);
    @(negedge clk); #2;
    tick = 1;
    rst = 1;
    #1;
    pin("async rst", 1, 8'h00, 0, 0);
    @(posedge clk); #1;
    tick = 0;
    rst = 0;
    step(1, 0, 0, 0, 0, 8'h00);
    ticks(1);
    pin("after rst", 1, 8'h01, 1, 0);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
